// File: rtl/i2c_master_arbiter_if.sv
// Bundle between the round-robin arbiter, its requesters and the single I2C master.
// The master modport is the arbiter's view; the slave modport is the clients/master side.
interface i2c_master_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [7*NREQ-1:0] req_addr;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_rw;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic [7:0]        rd_data;
    logic              busy;
    logic [6:0]        m_addr;
    logic [7:0]        m_data_in;
    logic              m_rw;
    logic              m_enable;
    logic [7:0]        m_data_out;
    logic              m_ready;

    modport master (
        input  req, req_addr, req_data, req_rw, m_data_out, m_ready,
        output gnt, done, err, rd_data, busy, m_addr, m_data_in, m_rw, m_enable
    );

    modport slave (
        output req, req_addr, req_data, req_rw, m_data_out, m_ready,
        input  gnt, done, err, rd_data, busy, m_addr, m_data_in, m_rw, m_enable
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// Round-robin scheduler sharing one I2C master among NREQ requesters, with a
// per-phase timeout. All outputs come straight from registers.
module i2c_master_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_master_arbiter_if.master bus
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_DONE, COMPLETE, ABORT} state_t;

    state_t            state_reg, state_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   done_reg, done_next;
    logic [NREQ-1:0]   err_reg, err_next;
    logic [7:0]        rd_data_reg, rd_data_next;
    logic [6:0]        m_addr_reg, m_addr_next;
    logic [7:0]        m_data_reg, m_data_next;
    logic              m_rw_reg, m_rw_next;
    logic              m_enable_reg, m_enable_next;
    logic              busy_reg, busy_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  ptr_reg, ptr_next;
    logic [IDX_W-1:0]  gidx_reg, gidx_next;
    logic [IDX_W-1:0]  win_idx, cand, ptr_after;
    logic              win_valid;

    logic [6:0] addr_arr [NREQ];
    logic [7:0] data_arr [NREQ];

    genvar gi;
    for (gi = 0; gi < NREQ; gi++) begin : g_fields
        assign addr_arr[gi] = bus.req_addr[7*gi +: 7];
        assign data_arr[gi] = bus.req_data[8*gi +: 8];
    end

    // Scan from the highest offset down so the closest set bit at/after ptr wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_reg) + i) % NREQ);
            if (bus.req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign ptr_after = (gidx_reg == IDX_W'(NREQ - 1)) ? '0 : gidx_reg + 1'b1;

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        done_next     = '0;
        err_next      = '0;
        rd_data_next  = rd_data_reg;
        m_addr_next   = m_addr_reg;
        m_data_next   = m_data_reg;
        m_rw_next     = m_rw_reg;
        m_enable_next = m_enable_reg;
        cnt_next      = cnt_reg;
        ptr_next      = ptr_reg;
        gidx_next     = gidx_reg;
        case (state_reg)
            IDLE: begin
                if (win_valid && bus.m_ready) begin
                    gidx_next     = win_idx;
                    gnt_next      = NREQ'(1) << win_idx;
                    m_addr_next   = addr_arr[win_idx];
                    m_data_next   = data_arr[win_idx];
                    m_rw_next     = bus.req_rw[win_idx];
                    m_enable_next = 1'b1;
                    cnt_next      = '0;
                    state_next    = LAUNCH;
                end
            end
            LAUNCH, WAIT_DONE: begin
                if (state_reg == LAUNCH && !bus.m_ready) begin
                    m_enable_next = 1'b0;
                    cnt_next      = '0;
                    state_next    = WAIT_DONE;
                end else if (state_reg == WAIT_DONE && bus.m_ready) begin
                    // done/rd_data/gnt are updated on the edge entering COMPLETE
                    // so the pulse lands exactly one cycle after ready is seen.
                    done_next  = gnt_reg;
                    gnt_next   = '0;
                    ptr_next   = ptr_after;
                    state_next = COMPLETE;
                    if (m_rw_reg) rd_data_next = bus.m_data_out;
                end else if (cnt_reg == CNT_W'(TIMEOUT)) begin
                    err_next      = gnt_reg;
                    gnt_next      = '0;
                    m_enable_next = 1'b0;
                    ptr_next      = ptr_after;
                    state_next    = ABORT;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            COMPLETE, ABORT: state_next = IDLE;
            default:         state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            done_reg     <= '0;
            err_reg      <= '0;
            rd_data_reg  <= '0;
            m_addr_reg   <= '0;
            m_data_reg   <= '0;
            m_rw_reg     <= 1'b0;
            m_enable_reg <= 1'b0;
            busy_reg     <= 1'b0;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
            gidx_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            done_reg     <= done_next;
            err_reg      <= err_next;
            rd_data_reg  <= rd_data_next;
            m_addr_reg   <= m_addr_next;
            m_data_reg   <= m_data_next;
            m_rw_reg     <= m_rw_next;
            m_enable_reg <= m_enable_next;
            busy_reg     <= busy_next;
            cnt_reg      <= cnt_next;
            ptr_reg      <= ptr_next;
            gidx_reg     <= gidx_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.done      = done_reg;
    assign bus.err       = err_reg;
    assign bus.rd_data   = rd_data_reg;
    assign bus.busy      = busy_reg;
    assign bus.m_addr    = m_addr_reg;
    assign bus.m_data_in = m_data_reg;
    assign bus.m_rw      = m_rw_reg;
    assign bus.m_enable  = m_enable_reg;
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench: one arbiter with a behavioural master model, and a second one
// with TIMEOUT=15 whose master is driven by hand to exercise the abort path.
module tb_i2c_master_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    i2c_master_arbiter_if #(.NREQ(4)) a ();
    i2c_master_arbiter_if #(.NREQ(4)) b ();

    i2c_master_arbiter #(.NREQ(4)) u_dut (.clk(clk), .rst(rst), .bus(a.master));
    i2c_master_arbiter #(.NREQ(4), .TIMEOUT(15)) u_dut_to (.clk(clk), .rst(rst), .bus(b.master));

    int         checks = 0;
    int         errors = 0;
    int         lat    = 40;
    logic [7:0] rsp    = 8'h00;

    // Master model: drops ready ~2 cycles after enable, raises it lat cycles later.
    initial begin
        a.m_ready    = 1'b1;
        a.m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (a.m_enable && a.m_ready) begin
                @(negedge clk);
                a.m_ready = 1'b0;
                repeat (lat) @(negedge clk);
                a.m_data_out = rsp;
                a.m_ready    = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        int n = 0;
        while (n < 200 && a.gnt == 4'b0000) begin
            @(negedge clk);
            n++;
        end
        g = a.gnt;
    endtask

    task automatic wait_done(output logic [3:0] d);
        int n = 0;
        while (n < 200 && a.done == 4'b0000) begin
            @(negedge clk);
            n++;
        end
        d = a.done;
    endtask

    logic [3:0] g, d;
    logic [3:0] exp_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         bad;

    initial begin
        a.req = '0; a.req_addr = '0; a.req_data = '0; a.req_rw = '0;
        b.req = '0; b.req_addr = '0; b.req_data = '0; b.req_rw = '0;
        b.m_ready = 1'b1; b.m_data_out = 8'h00;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(a.gnt), 'b0);
        check("rst_busy", 32'(a.busy), 'b0);
        check("rst_m_enable", 32'(a.m_enable), 'b0);
        check("rst_rd_data", 32'(a.rd_data), 'h0);
        check("rst_m_addr", 32'(a.m_addr), 'h0);
        rst = 1'b1;
        @(negedge clk);

        // Single write from requester 0
        a.req_addr[6:0] = 7'h2A; a.req_data[7:0] = 8'hAA; a.req_rw = 4'b0000; a.req = 4'b0001;
        @(negedge clk);
        check("wr_gnt", 32'(a.gnt), 'b0001);
        check("wr_m_addr", 32'(a.m_addr), 'h2A);
        check("wr_m_data_in", 32'(a.m_data_in), 'hAA);
        check("wr_m_rw", 32'(a.m_rw), 'b0);
        check("wr_m_enable", 32'(a.m_enable), 'b1);
        check("wr_busy", 32'(a.busy), 'b1);
        wait_done(d);
        a.req = 4'b0000;
        check("wr_done", 32'(d), 'b0001);
        check("wr_gnt_falls", 32'(a.gnt), 'b0);
        check("wr_rd_data_kept", 32'(a.rd_data), 'h0);
        @(negedge clk);
        check("wr_done_pulse", 32'(a.done), 'b0);

        // Rotation past idle bits: ptr=1, req=1001 -> 3 then 0
        lat = 3;
        a.req = 4'b1001;
        wait_gnt(g);
        check("rot_first", 32'(g), 'b1000);
        wait_done(d);
        check("rot_first_done", 32'(d), 'b1000);
        a.req = 4'b0001;
        wait_gnt(g);
        check("rot_second", 32'(g), 'b0001);
        wait_done(d);
        check("rot_second_done", 32'(d), 'b0001);
        a.req = 4'b0000;

        // Single read from requester 2
        rsp = 8'h5C;
        a.req_addr[20:14] = 7'h33; a.req_rw = 4'b0100; a.req = 4'b0100;
        wait_gnt(g);
        check("rd_gnt", 32'(g), 'b0100);
        check("rd_m_addr", 32'(a.m_addr), 'h33);
        check("rd_m_rw", 32'(a.m_rw), 'b1);
        bad = 0;
        for (int n = 0; n < 200 && a.done == 4'b0000; n++) begin
            if (a.gnt !== 4'b0100) bad++;
            @(negedge clk);
        end
        a.req = 4'b0000;
        check("rd_gnt_held", 32'(bad), 'd0);
        check("rd_done", 32'(a.done), 'b0100);
        check("rd_data", 32'(a.rd_data), 'h5C);

        // Reset during WAIT_DONE (ptr=3, req=0010 -> grant 1)
        lat = 40; a.req_rw = 4'b0000; a.req = 4'b0010;
        wait_gnt(g);
        check("mid_gnt", 32'(g), 'b0010);
        repeat (5) @(negedge clk);
        check("mid_waiting_enable", 32'(a.m_enable), 'b0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_gnt", 32'(a.gnt), 'b0);
        check("mid_rst_busy", 32'(a.busy), 'b0);
        check("mid_rst_rd_data", 32'(a.rd_data), 'h0);
        check("mid_rst_m_addr", 32'(a.m_addr), 'h0);
        check("mid_rst_done_err", 32'({a.done, a.err}), 'h0);
        rst = 1'b1;
        lat = 3;

        // Contention from reset: 0,1,2,3 then 0, no stray done/err meanwhile
        a.req = 4'b1111;
        bad = 0;
        for (int n = 0; n < 200 && a.gnt == 4'b0000; n++) begin
            if (a.done != 4'b0000 || a.err != 4'b0000) bad++;
            @(negedge clk);
        end
        check("post_rst_no_pulse", 32'(bad), 'd0);
        for (int t = 0; t < 5; t++) begin
            wait_gnt(g);
            check("cont_order", 32'(g), 32'(exp_order[t]));
            wait_done(d);
            check("cont_done", 32'(d), 32'(exp_order[t]));
        end
        a.req = 4'b0000;

        // Timeout on the TIMEOUT=15 instance: master never drops ready
        b.req = 4'b0001;
        @(negedge clk);
        check("to_gnt", 32'(b.gnt), 'b0001);
        check("to_enable", 32'(b.m_enable), 'b1);
        repeat (15) @(negedge clk);
        check("to_err_early", 32'(b.err), 'b0);
        @(negedge clk);
        b.req = 4'b0000;
        check("to_err", 32'(b.err), 'b0001);
        check("to_gnt_clear", 32'(b.gnt), 'b0);
        check("to_enable_clear", 32'(b.m_enable), 'b0);
        @(negedge clk);
        check("to_err_pulse", 32'(b.err), 'b0);
        check("to_busy", 32'(b.busy), 'b0);

        // Next request on that instance is served normally (req dropped mid-flight)
        b.req_rw = 4'b0010; b.req = 4'b0010;
        @(negedge clk);
        check("to_next_gnt", 32'(b.gnt), 'b0010);
        check("to_next_enable", 32'(b.m_enable), 'b1);
        b.m_ready = 1'b0; b.req = 4'b0000;
        @(negedge clk);
        check("to_next_enable_drop", 32'(b.m_enable), 'b0);
        b.m_data_out = 8'h77; b.m_ready = 1'b1;
        @(negedge clk);
        check("to_next_done", 32'(b.done), 'b0010);
        check("to_next_rd_data", 32'(b.rd_data), 'h77);
        check("to_next_gnt_clear", 32'(b.gnt), 'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
